// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - sequential shift-and-add multiplier over a ripple adder; optional EARLY_TERM_EN
// Result is (x*y) mod 2^maxn. Defining EARLY_TERM_EN ends RUN once the
// remaining multiplier bits are all zero; results are identical either way.

module mult_seq_adder #(
  parameter int maxn = 16
) (
  input  logic [maxn-1:0] x,
  input  logic [maxn-1:0] y,
  output logic [maxn-1:0] sum
);

  logic carry;

  // Ripple carry chain, LSB first; the final carry is dropped (modulo add)
  always_comb begin
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < maxn; i++) begin
      sum[i] = x[i] ^ y[i] ^ carry;
      carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
  end

endmodule

module mult_seq #(
  parameter int maxn = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [maxn-1:0] x,
  input  logic [maxn-1:0] y,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [maxn-1:0] prod
);

  localparam int cw = (maxn > 1) ? $clog2(maxn) : 1;
  localparam logic [cw-1:0] last_cnt = cw'(maxn - 1);

  localparam logic [1:0] s_idle = 2'd0;
  localparam logic [1:0] s_run  = 2'd1;
  localparam logic [1:0] s_done = 2'd2;

  logic [1:0]      state;
  logic [maxn-1:0] acc;
  logic [maxn-1:0] mcand;
  logic [maxn-1:0] mplier;
  logic [cw-1:0]   cnt;
  logic [maxn-1:0] prod_q;

  logic [maxn-1:0] sum;
  logic [maxn-1:0] acc_next;
  logic [maxn-1:0] mplier_next;
  logic            run_last;

  mult_seq_adder #(.maxn(maxn)) u_adder (
    .x   (acc),
    .y   (mcand),
    .sum (sum)
  );

  // Next-step values for one RUN iteration and the exit condition
  always_comb begin
    acc_next    = mplier[0] ? sum : acc;
    mplier_next = mplier >> 1;
`ifdef EARLY_TERM_EN
    run_last    = (cnt == last_cnt) || (mplier_next == '0);
`else
    run_last    = (cnt == last_cnt);
`endif
  end

  // Handshake/FSM sequencing and datapath registers; rst aborts any op in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= s_idle;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
      prod_q <= '0;
    end else begin
      case (state)
        s_idle: begin
          if (in_valid) begin
            acc    <= '0;
            mcand  <= x;
            mplier <= y;
            cnt    <= '0;
            state  <= s_run;
          end
        end
        s_run: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier_next;
          cnt    <= cnt + 1'b1;
          if (run_last) begin
            // prod is captured with the final sum so it is valid on DONE entry
            prod_q <= acc_next;
            state  <= s_done;
          end
        end
        s_done: begin
          if (out_ready) begin
            state <= s_idle;
          end
        end
        default: state <= s_idle;
      endcase
    end
  end

  // Handshake outputs decode directly from state
  always_comb begin
    in_ready  = (state == s_idle);
    out_valid = (state == s_done);
    prod      = prod_q;
  end

endmodule

// File: tb/tb_mult_seq.sv
// tb/tb_mult_seq.sv - table-driven self-checking bench for mult_seq

module tb_mult_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x;
  logic [15:0] y;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] prod;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string       name;
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] p;
    int          lat_early;
  } vec_t;

  vec_t tv[6];

  mult_seq #(.maxn(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int lat_early);
`ifdef EARLY_TERM_EN
    return lat_early;
`else
    return 17;
`endif
  endfunction

  // One complete operation; latency counted in negedges after the accept edge
  task automatic run_op(input string name, input logic [15:0] ax, input logic [15:0] ay,
                        input logic [15:0] p_exp, input int lat_exp,
                        input bit noisy, input bit bp);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({name, " in_ready_idle"}, 32'(in_ready), 32'd1);
    x = ax;
    y = ay;
    in_valid = 1'b1;
    out_ready = !bp;
    @(negedge clk);
    n = 1;
    if (noisy) begin
      x = 16'($urandom);
      y = 16'($urandom);
    end else begin
      in_valid = 1'b0;
    end
    chk({name, " in_ready_run"}, 32'(in_ready), 32'd0);
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
      if (noisy) begin
        x = 16'($urandom);
        y = 16'($urandom);
      end
    end
    in_valid = 1'b0;
    chk({name, " latency"}, 32'(n), 32'(lat_exp));
    chk({name, " prod"}, 32'(prod), 32'(p_exp));
    if (bp) begin
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        chk({name, " bp_out_valid"}, 32'(out_valid), 32'd1);
        chk({name, " bp_prod"}, 32'(prod), 32'(p_exp));
        chk({name, " bp_in_ready"}, 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    chk({name, " in_ready_after"}, 32'(in_ready), 32'd1);
    chk({name, " out_valid_after"}, 32'(out_valid), 32'd0);
    chk({name, " prod_hold"}, 32'(prod), 32'(p_exp));
  endtask

  initial begin
    int seen;
    tv[0] = '{"t3x5",      16'h0003, 16'h0005, 16'h000F, 4};
    tv[1] = '{"ffffxffff", 16'hFFFF, 16'hFFFF, 16'h0001, 17};
    tv[2] = '{"wrap8000",  16'h8000, 16'h0002, 16'h0000, 3};
    tv[3] = '{"yzero",     16'h1234, 16'h0000, 16'h0000, 2};
    tv[4] = '{"ffx101",    16'h00FF, 16'h0101, 16'hFFFF, 10};
    tv[5] = '{"big",       16'h1234, 16'h5678, 16'h0060, 16};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    x = '0;
    y = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset prod", 32'(prod), 32'd0);

    for (int i = 0; i < 6; i++) begin
      run_op(tv[i].name, tv[i].x, tv[i].y, tv[i].p, lat_of(tv[i].lat_early), 1'b0, 1'b0);
    end

    // Backpressure in DONE
    run_op("bp", 16'h0003, 16'h0005, 16'h000F, lat_of(4), 1'b0, 1'b1);

    // in_valid held with changing operands during RUN
    run_op("noisy", 16'h0007, 16'h0009, 16'h003F, lat_of(5), 1'b1, 1'b0);

    // Reset pulse in RUN cycle 8 aborts the op
    x = 16'h1234;
    y = 16'h5678;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort prod", 32'(prod), 32'd0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("abort no_result", 32'(seen), 32'd0);
    run_op("after_abort", 16'h0002, 16'h0003, 16'h0006, lat_of(3), 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
